factorial_arbiter: RTL and testbench
====================================

FACTORIAL_ARBITER -- requirements
Module: factorial_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum WAIT cycles before a job is aborted.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports req0/req1  input  1  requester k holds high until done_k.
REQ-005 SHALL have ports val0/val1  input  32  operand of requester k, stable while req_k is high.
REQ-006 SHALL have ports done0/done1  output  1  one-cycle completion pulse to requester k.
REQ-007 SHALL have port result  output  32  factorial result, valid while any done_k is high.
REQ-008 SHALL have port overflow  output  1  result exceeds 32 bits, valid with done_k.
REQ-009 SHALL have port timeout  output  1  job aborted by TIMEOUT, valid with done_k.
REQ-010 SHALL have port fact_val  output  32  operand driven to the shared factorial unit.
REQ-011 SHALL have port fact_start  output  1  one-cycle start pulse to the factorial unit.
REQ-012 SHALL have port fact_result  input  32  factorial unit result.
REQ-013 SHALL have port fact_ready  input  1  factorial unit result valid.
REQ-014 SHALL have port fact_overflow  input  1  factorial unit overflow flag.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, RESP; IDLE is the reset state.
REQ-016 In IDLE, a sampled request SHALL be granted; the FSM SHALL move to ISSUE if the operand is 2..12, otherwise to RESP (fast path).
REQ-017 If both requests are high in IDLE, the grant SHALL go to the requester not granted last (round-robin); last_grant SHALL reset to 1, so req0 wins first.
REQ-018 The granted index and operand SHALL be latched at grant; later changes on val_k SHALL be ignored.
REQ-019 Fast path, operand 0 or 1: RESP with result=1, overflow=0, timeout=0, and the unit untouched.
REQ-020 Fast path, operand >12: RESP with result=0, overflow=1, timeout=0, and the unit untouched.
REQ-021 In ISSUE, the block SHALL assert fact_start=1 for exactly one cycle, hold fact_val at the latched operand, then go to WAIT.
REQ-022 fact_val SHALL stay at the latched operand through ISSUE and WAIT; it SHALL be 0 otherwise.
REQ-023 In WAIT, a 7-bit counter SHALL count cycles from 0; fact_ready SHALL be ignored while the count is 0, to reject a stale ready.
REQ-024 In WAIT, with count ≥1 and fact_ready=1, the block SHALL capture fact_result and fact_overflow and go to RESP.
REQ-025 In WAIT, when count reaches TIMEOUT-1 without a qualifying fact_ready, the block SHALL go to RESP with result=0, overflow=0, timeout=1.
REQ-026 If fact_ready and timeout occur in the same cycle, fact_ready SHALL win.
REQ-027 In RESP, the block SHALL pulse done_k for the granted k only, for one cycle, then return to IDLE.
REQ-028 result, overflow and timeout SHALL be 0 whenever neither done is high.
REQ-029 Latency SHALL be fixed: fast path gives done 2 cycles after the req sample edge; unit path gives done 2 cycles after the qualifying fact_ready edge.
REQ-030 A req_k still high in the IDLE cycle after done_k SHALL be treated as a new request, subject to round-robin.
REQ-031 A request SHALL never be dropped; a non-granted requester SHALL be served no later than after the current job.

Reset
REQ-032 On rst=1, asynchronously: state=IDLE, counter=0, last_grant=1, latched operand=0, and all outputs 0.
REQ-033 Reset mid-job SHALL abort the job with no done pulse; after release the requester SHALL re-present the request.
REQ-034 The first grant SHALL occur no earlier than the first rising clk after rst deasserts.

Verification
REQ-035 Bench case: req0=1, val0=4; unit returns ready with 24 three cycles after start -> done0=1 one cycle, result=24, overflow=0, timeout=0.
REQ-036 Bench case: req1=1, val1=16 -> no fact_start, done1 two cycles later, result=0, overflow=1.
REQ-037 Bench case: req0=1, val0=0 -> done0 with result=1; then val0=1 -> result=1; fact_start never asserted.
REQ-038 Bench case: req0=req1=1 held, with val0=5 and val1=6 -> grants alternate 0,1,0,…; results 120 and 720; no starvation.
REQ-039 Bench case: req0=1, val0=7, fact_ready held 0 -> done0 after TIMEOUT WAIT cycles with timeout=1, result=0.
REQ-040 Bench case: assert rst during WAIT -> all outputs 0 immediately, no done; after release, re-request val0=3 gives result=6.

Source files
------------

// File: rtl/factorial_arbiter_if.sv
// Bundle of requester-side and factorial-unit-side signals for factorial_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface factorial_arbiter_if;
   logic        req0;
   logic        req1;
   logic [31:0] val0;
   logic [31:0] val1;
   logic        done0;
   logic        done1;
   logic [31:0] result;
   logic        overflow;
   logic        timeout;
   logic [31:0] fact_val;
   logic        fact_start;
   logic [31:0] fact_result;
   logic        fact_ready;
   logic        fact_overflow;

   modport slave (
      input  req0, req1, val0, val1, fact_result, fact_ready, fact_overflow,
      output done0, done1, result, overflow, timeout, fact_val, fact_start
   );

   modport master (
      output req0, req1, val0, val1, fact_result, fact_ready, fact_overflow,
      input  done0, done1, result, overflow, timeout, fact_val, fact_start
   );
endinterface

// File: rtl/factorial_arbiter.sv
// Round-robin arbiter sharing one factorial unit between two requesters.
// Trivial operands bypass the unit; a stalled unit is abandoned after TIMEOUT WAIT cycles.
module factorial_arbiter #(
   parameter int unsigned TIMEOUT = 64
) (
   input logic                clk,
   input logic                rst,
   factorial_arbiter_if.slave bus_io
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   localparam logic [6:0] CntLast = 7'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;
   logic        last_q, last_d;
   logic        gnt_q, gnt_d;
   logic [31:0] op_q, op_d;
   logic [31:0] rsp_result_q, rsp_result_d;
   logic        rsp_ovf_q, rsp_ovf_d;
   logic        rsp_to_q, rsp_to_d;
   logic [1:0]  done_q, done_d;

   logic        sel;
   logic [31:0] sel_op;

   // With both requesting, the one not served last wins.
   assign sel    = (bus_io.req0 && bus_io.req1) ? ~last_q : bus_io.req1;
   assign sel_op = sel ? bus_io.val1 : bus_io.val0;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_d       = last_q;
      gnt_d        = gnt_q;
      op_d         = op_q;
      rsp_result_d = rsp_result_q;
      rsp_ovf_d    = rsp_ovf_q;
      rsp_to_d     = rsp_to_q;
      done_d       = 2'b00;

      unique case (state_q)
         StIdle: begin
            if (bus_io.req0 || bus_io.req1) begin
               gnt_d  = sel;
               last_d = sel;
               op_d   = sel_op;
               cnt_d  = 7'd0;
               if (sel_op >= 32'd2 && sel_op <= 32'd12) begin
                  state_d = StIssue;
               end else begin
                  state_d      = StResp;
                  rsp_result_d = (sel_op < 32'd2) ? 32'd1 : 32'd0;
                  rsp_ovf_d    = (sel_op > 32'd12);
                  rsp_to_d     = 1'b0;
               end
            end
         end
         StIssue: begin
            state_d = StWait;
            cnt_d   = 7'd0;
         end
         StWait: begin
            // A ready seen at count 0 may belong to a previous job, so it is ignored.
            if (cnt_q != 7'd0 && bus_io.fact_ready) begin
               state_d      = StResp;
               rsp_result_d = bus_io.fact_result;
               rsp_ovf_d    = bus_io.fact_overflow;
               rsp_to_d     = 1'b0;
            end else if (cnt_q == CntLast) begin
               state_d      = StResp;
               rsp_result_d = 32'd0;
               rsp_ovf_d    = 1'b0;
               rsp_to_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + 7'd1;
            end
         end
         StResp: begin
            done_d  = gnt_q ? 2'b10 : 2'b01;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= 7'd0;
         last_q       <= 1'b1;
         gnt_q        <= 1'b0;
         op_q         <= 32'd0;
         rsp_result_q <= 32'd0;
         rsp_ovf_q    <= 1'b0;
         rsp_to_q     <= 1'b0;
         done_q       <= 2'b00;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_q       <= last_d;
         gnt_q        <= gnt_d;
         op_q         <= op_d;
         rsp_result_q <= rsp_result_d;
         rsp_ovf_q    <= rsp_ovf_d;
         rsp_to_q     <= rsp_to_d;
         done_q       <= done_d;
      end
   end

   assign bus_io.done0      = done_q[0];
   assign bus_io.done1      = done_q[1];
   assign bus_io.result     = (|done_q) ? rsp_result_q : 32'd0;
   assign bus_io.overflow   = (|done_q) ? rsp_ovf_q : 1'b0;
   assign bus_io.timeout    = (|done_q) ? rsp_to_q : 1'b0;
   assign bus_io.fact_start = (state_q == StIssue);
   assign bus_io.fact_val   = (state_q == StIssue || state_q == StWait) ? op_q : 32'd0;

endmodule

// File: tb/tb_factorial_arbiter.sv
// Randomised self-checking bench for factorial_arbiter with a behavioural factorial unit
// and a job-level reference model.
module tb_factorial_arbiter;
   localparam int unsigned TIMEOUT = 64;

   bit   clk;
   logic rst;
   int   checks;
   int   errors;

   // Behavioural factorial unit: answers unit_delay edges after the start edge; 0 = never.
   int          unit_delay;
   logic        unit_ovf;
   int          unit_cnt;
   logic [31:0] unit_op;

   // Observations of the latest job
   logic [31:0] g_res;
   logic        g_ovf, g_to;
   int          g_lat, g_st;
   logic [31:0] g_sval;
   bit          g_other, g_leak;

   // Model expectations
   logic [31:0] e_res;
   logic        e_ovf, e_to;
   int          e_lat, e_st;
   logic [31:0] e_sval;

   factorial_arbiter_if bus ();

   factorial_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_fact(input logic [31:0] n);
      logic [63:0] acc;
      acc = 64'd1;
      for (int i = 2; i <= int'(n); i++) acc = acc * 64'(i);
      return acc;
   endfunction

   // Job outcome from the operand and unit behaviour; latency counts edges from the grant edge
   // (edge 1) to the edge after which done is visible.
   function automatic void model_job(input logic [31:0] v, input int d, input logic inj);
      logic [63:0] f;
      if (v <= 32'd1) begin
         e_res = 32'd1; e_ovf = 1'b0; e_to = 1'b0; e_lat = 2; e_st = 0; e_sval = 32'd0;
      end else if (v > 32'd12) begin
         e_res = 32'd0; e_ovf = 1'b1; e_to = 1'b0; e_lat = 2; e_st = 0; e_sval = 32'd0;
      end else if (d >= 2 && d <= int'(TIMEOUT)) begin
         f = ref_fact(v);
         e_res = f[31:0]; e_ovf = inj; e_to = 1'b0; e_lat = d + 3; e_st = 1; e_sval = v;
      end else begin
         e_res = 32'd0; e_ovf = 1'b0; e_to = 1'b1; e_lat = int'(TIMEOUT) + 3; e_st = 1;
         e_sval = v;
      end
   endfunction

   function automatic logic [68:0] out_vec();
      return {bus.done0, bus.done1, bus.result, bus.overflow, bus.timeout, bus.fact_val,
              bus.fact_start};
   endfunction

   initial begin
      logic [63:0] f;
      bus.fact_ready = 1'b0; bus.fact_result = 32'd0; bus.fact_overflow = 1'b0;
      unit_cnt = 0; unit_op = 32'd0;
      forever begin
         @(posedge clk); #1;
         bus.fact_ready = 1'b0; bus.fact_result = 32'd0; bus.fact_overflow = 1'b0;
         if (rst) begin
            unit_cnt = 0;
         end else begin
            if (unit_cnt > 0) begin
               unit_cnt--;
               if (unit_cnt == 0) begin
                  f = ref_fact(unit_op);
                  bus.fact_ready = 1'b1; bus.fact_result = f[31:0]; bus.fact_overflow = unit_ovf;
               end
            end
            if (bus.fact_start && unit_delay > 0) begin
               unit_cnt = unit_delay;
               unit_op  = bus.fact_val;
            end
         end
      end
   end

   // Requester k presents v and holds until its done; called #1 after an edge.
   task automatic run_job(input int k, input logic [31:0] v, input int d, input logic inj,
                          input bit scramble);
      unit_delay = d; unit_ovf = inj;
      if (k == 0) begin bus.req0 = 1'b1; bus.val0 = v; end
      else begin bus.req1 = 1'b1; bus.val1 = v; end
      g_res = 32'hdead_beef; g_ovf = 1'bx; g_to = 1'bx;
      g_lat = 0; g_st = 0; g_sval = 32'd0; g_other = 0; g_leak = 0;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk); #1;
         if (scramble && n == 1) begin
            if (k == 0) bus.val0 = $urandom; else bus.val1 = $urandom;
         end
         if (bus.fact_start) begin g_st++; g_sval = bus.fact_val; end
         if ((k == 0) ? bus.done1 : bus.done0) g_other = 1;
         if (!bus.done0 && !bus.done1 && (bus.result != 0 || bus.overflow || bus.timeout))
            g_leak = 1;
         if ((k == 0) ? bus.done0 : bus.done1) begin
            g_lat = n; g_res = bus.result; g_ovf = bus.overflow; g_to = bus.timeout;
            break;
         end
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
   endtask

   task automatic test_reset();
      logic [68:0] ov;
      rst = 1'b1; bus.req0 = 1'b1; bus.val0 = 32'd5;
      repeat (3) @(posedge clk);
      #1;
      ov = out_vec();
      checks++;
      if (ov !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", ov); end
      bus.req0 = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      ov = out_vec();
      checks++;
      if (ov !== '0) begin errors++; $display("FAIL idle_outputs: got %h expected 0", ov); end
   endtask

   task automatic test_unit_path();
      run_job(0, 32'd4, 3, 1'b0, 1'b0);
      model_job(32'd4, 3, 1'b0);
      checks++;
      if ({g_res, g_ovf, g_to} !== {e_res, e_ovf, e_to} || e_res !== 32'd24) begin
         errors++;
         $display("FAIL unit_path_resp: got res=%0d ovf=%b to=%b expected res=%0d ovf=%b to=%b",
                  g_res, g_ovf, g_to, e_res, e_ovf, e_to);
      end
      checks++;
      if (g_lat !== e_lat || g_st !== e_st || g_sval !== e_sval) begin
         errors++;
         $display("FAIL unit_path_timing: got lat=%0d starts=%0d val=%0d expected %0d %0d %0d",
                  g_lat, g_st, g_sval, e_lat, e_st, e_sval);
      end
   endtask

   task automatic test_fast_overflow();
      run_job(1, 32'd16, 3, 1'b0, 1'b0);
      model_job(32'd16, 3, 1'b0);
      checks++;
      if ({g_res, g_ovf, g_to} !== {e_res, e_ovf, e_to} || g_lat !== e_lat || g_st !== 0) begin
         errors++;
         $display("FAIL fast_overflow: got res=%0d ovf=%b to=%b lat=%0d starts=%0d expected %0d %b %b %0d 0",
                  g_res, g_ovf, g_to, g_lat, g_st, e_res, e_ovf, e_to, e_lat);
      end
      checks++;
      if ({g_other, g_leak} !== 2'b00) begin
         errors++; $display("FAIL fast_overflow_stray: got other=%b leak=%b expected 0 0",
                            g_other, g_leak);
      end
   endtask

   task automatic test_small_operands();
      for (int v = 0; v < 2; v++) begin
         run_job(0, 32'(v), 3, 1'b0, 1'b0);
         model_job(32'(v), 3, 1'b0);
         checks++;
         if ({g_res, g_ovf, g_to} !== {e_res, e_ovf, e_to} || g_lat !== e_lat || g_st !== 0) begin
            errors++;
            $display("FAIL small_operand_%0d: got res=%0d ovf=%b to=%b lat=%0d starts=%0d expected %0d %b %b %0d 0",
                     v, g_res, g_ovf, g_to, g_lat, g_st, e_res, e_ovf, e_to, e_lat);
         end
      end
   endtask

   task automatic test_round_robin();
      int exp_k, k;
      bit got, both;
      logic [31:0] r;
      logic [63:0] f;
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      unit_delay = 3; unit_ovf = 1'b0;
      bus.req0 = 1'b1; bus.val0 = 32'd5; bus.req1 = 1'b1; bus.val1 = 32'd6;
      exp_k = 0;
      for (int j = 0; j < 6; j++) begin
         got = 0; k = -1; both = 0; r = 32'd0;
         for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (bus.done0 || bus.done1) begin
               got = 1; k = bus.done1 ? 1 : 0; both = bus.done0 && bus.done1; r = bus.result;
               break;
            end
         end
         f = ref_fact(exp_k == 0 ? 32'd5 : 32'd6);
         checks++;
         if (!got || both || k != exp_k) begin
            errors++; $display("FAIL rr_grant_%0d: got requester %0d expected %0d", j, k, exp_k);
         end
         checks++;
         if (r !== f[31:0]) begin
            errors++; $display("FAIL rr_result_%0d: got %0d expected %0d", j, r, f[31:0]);
         end
         exp_k = 1 - exp_k;
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
   endtask

   task automatic test_timeout();
      run_job(0, 32'd7, 0, 1'b0, 1'b0);
      model_job(32'd7, 0, 1'b0);
      checks++;
      if ({g_res, g_ovf, g_to} !== {e_res, e_ovf, e_to} || g_lat !== e_lat) begin
         errors++;
         $display("FAIL timeout: got res=%0d ovf=%b to=%b lat=%0d expected %0d %b %b %0d",
                  g_res, g_ovf, g_to, g_lat, e_res, e_ovf, e_to, e_lat);
      end
   endtask

   // Ready on the last WAIT cycle, one cycle late, stale at count 0, and earliest legal.
   task automatic test_ready_boundary();
      int dl [4];
      dl = '{int'(TIMEOUT), int'(TIMEOUT) + 1, 1, 2};
      foreach (dl[i]) begin
         run_job(0, 32'd7, dl[i], 1'b1, 1'b0);
         model_job(32'd7, dl[i], 1'b1);
         checks++;
         if ({g_res, g_ovf, g_to} !== {e_res, e_ovf, e_to} || g_lat !== e_lat) begin
            errors++;
            $display("FAIL ready_boundary_d%0d: got res=%0d ovf=%b to=%b lat=%0d expected %0d %b %b %0d",
                     dl[i], g_res, g_ovf, g_to, g_lat, e_res, e_ovf, e_to, e_lat);
         end
      end
   endtask

   task automatic test_reset_mid_job();
      logic [68:0] ov;
      int n_done;
      unit_delay = 0;
      bus.req0 = 1'b1; bus.val0 = 32'd3;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (bus.fact_val !== 32'd3 || bus.fact_start !== 1'b0) begin
         errors++; $display("FAIL wait_hold_val: got val=%0d start=%b expected 3 0",
                            bus.fact_val, bus.fact_start);
      end
      #2 rst = 1'b1;
      #1 ov = out_vec();
      checks++;
      if (ov !== '0) begin errors++; $display("FAIL midjob_reset_outputs: got %h expected 0", ov); end
      bus.req0 = 1'b0;
      n_done = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (bus.done0 || bus.done1) n_done++;
      end
      checks++;
      if (n_done != 0) begin errors++; $display("FAIL midjob_no_done: got %0d expected 0", n_done); end
      rst = 1'b0;
      run_job(0, 32'd3, 3, 1'b0, 1'b0);
      checks++;
      if ({g_res, g_ovf, g_to} !== {32'd6, 1'b0, 1'b0}) begin
         errors++; $display("FAIL midjob_rerequest: got res=%0d ovf=%b to=%b expected 6 0 0",
                            g_res, g_ovf, g_to);
      end
   endtask

   task automatic test_random();
      int k, d, r;
      logic [31:0] v;
      logic inj;
      for (int j = 0; j < 24; j++) begin
         k = $urandom_range(0, 1);
         r = $urandom_range(0, 9);
         v = (r == 0) ? $urandom : 32'($urandom_range(0, 14));
         r = $urandom_range(0, 9);
         d = (r == 0) ? 0 : (r == 1) ? 1 : $urandom_range(2, 12);
         inj = 1'($urandom_range(0, 1));
         run_job(k, v, d, inj, 1'b1);
         model_job(v, d, inj);
         checks++;
         if ({g_res, g_ovf, g_to} !== {e_res, e_ovf, e_to}) begin
            errors++;
            $display("FAIL rand_%0d_resp (k=%0d v=%0d d=%0d): got res=%0d ovf=%b to=%b expected %0d %b %b",
                     j, k, v, d, g_res, g_ovf, g_to, e_res, e_ovf, e_to);
         end
         checks++;
         if (g_lat !== e_lat || g_st !== e_st || g_sval !== e_sval || g_other || g_leak) begin
            errors++;
            $display("FAIL rand_%0d_timing: got lat=%0d starts=%0d val=%0d other=%b leak=%b expected %0d %0d %0d 0 0",
                     j, g_lat, g_st, g_sval, g_other, g_leak, e_lat, e_st, e_sval);
         end
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1; unit_delay = 0; unit_ovf = 1'b0;
      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.val0 = 32'd0; bus.val1 = 32'd0;
      test_reset();
      test_unit_path();
      test_fast_overflow();
      test_small_operands();
      test_round_robin();
      test_timeout();
      test_ready_boundary();
      test_reset_mid_job();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
